// File: rtl/ldpc_enc_pkg.sv
// Shared constants and state encoding for the LDPC encoder slice.
// Used by parallel_encode, control_encode and parity_out.
package ldpc_enc_pkg;

    localparam int unsigned PARITY_W_DEF = 2048;
    localparam int unsigned OUT_W_DEF    = 16;
    localparam int unsigned NWORDS_DEF   = PARITY_W_DEF / OUT_W_DEF;
    localparam int unsigned CNT_W_DEF    = $clog2(NWORDS_DEF);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOADED = 2'd1,
        SHIFT  = 2'd2,
        DONE   = 2'd3
    } enc_out_state_e;

    // A single-word codeword still needs a 1-bit counter.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/parity_out.sv
// Serialises a loaded parity vector into OUT_W-bit words toward the flash
// controller, LSB word first, one word per enabled cycle.
module parity_out
    import ldpc_enc_pkg::*;
#(
    parameter int unsigned PARITY_W = PARITY_W_DEF,
    parameter int unsigned OUT_W    = OUT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PARITY_W-1:0] parity_in,
    input  logic                load_parity,
    input  logic                en_counterOUT,
    input  logic                en_out,
    input  logic                rst_c,
    output logic [OUT_W-1:0]    parity_dout,
    output logic                parity_valid,
    output logic                parity_out_done,
    output logic                parity_err
);

    localparam int unsigned NWORDS = PARITY_W / OUT_W;
    localparam int unsigned CNT_W  = cnt_width(NWORDS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NWORDS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    enc_out_state_e      state_q, state_d;
    logic [PARITY_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [OUT_W-1:0]    dout_q,  dout_d;
    logic                valid_q, valid_d;
    logic                done_q,  done_d;
    logic                err_q,   err_d;
    logic                adv_s;

    assign adv_s = en_counterOUT & en_out;

    // State and datapath registers; rst overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state: rst_c clear beats load, load beats advance.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        done_d  = done_q;
        err_d   = err_q;

        if (!rst_c) begin
            state_d = IDLE;
            shreg_d = '0;
            cnt_d   = '0;
            dout_d  = '0;
            done_d  = 1'b0;
        end else if (load_parity) begin
            state_d = LOADED;
            shreg_d = parity_in;
            cnt_d   = '0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (adv_s) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                end
                LOADED, SHIFT: begin
                    if (adv_s) begin
                        dout_d  = shreg_q[OUT_W-1:0];
                        shreg_d = shreg_q >> OUT_W;
                        valid_d = 1'b1;
                        // Counter parks on the last index rather than wrapping.
                        if (cnt_q == LAST_CNT) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = SHIFT;
                            cnt_d   = cnt_q + CNT_ONE;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                DONE: begin
                    if (adv_s) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign parity_dout     = dout_q;
    assign parity_valid    = valid_q;
    assign parity_out_done = done_q;
    assign parity_err      = err_q;

endmodule

// File: tb/tb_parity_out.sv
// Scoreboard bench for parity_out: a word-queue reference model predicts each
// output word; a negedge monitor pops and compares.
module tb_parity_out;

    localparam int PW = 2048;
    localparam int OW = 16;
    localparam int NW = PW / OW;

    logic          clk = 1'b0;
    logic          rst, rst_c, load_parity, en_counterOUT, en_out;
    logic [PW-1:0] parity_in;
    logic [OW-1:0] parity_dout;
    logic          parity_valid, parity_out_done, parity_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [OW-1:0] words[$];
    logic [OW-1:0] sb[$];
    logic [OW-1:0] m_dout = '0;
    bit            m_active = 1'b0;
    bit            m_done = 1'b0;
    bit            m_err = 1'b0;

    parity_out #(.PARITY_W(PW), .OUT_W(OW)) dut (
        .clk            (clk),
        .rst            (rst),
        .parity_in      (parity_in),
        .load_parity    (load_parity),
        .en_counterOUT  (en_counterOUT),
        .en_out         (en_out),
        .rst_c          (rst_c),
        .parity_dout    (parity_dout),
        .parity_valid   (parity_valid),
        .parity_out_done(parity_out_done),
        .parity_err     (parity_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] ramp(input bit inv);
        logic [PW-1:0] v;
        logic [OW-1:0] w;
        v = '0;
        for (int k = 0; k < NW; k++) begin
            w = OW'(k);
            if (inv) w = ~w;
            v[k*OW +: OW] = w;
        end
        return v;
    endfunction

    function automatic logic [PW-1:0] rand_vec();
        logic [PW-1:0] v;
        for (int i = 0; i < PW / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    // Reference model: a loaded codeword is just a queue of words popped per advance.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                words.delete();
                m_active = 1'b0; m_done = 1'b0; m_err = 1'b0; m_dout = '0;
            end else if (!rst_c) begin
                words.delete();
                m_active = 1'b0; m_done = 1'b0; m_dout = '0;
            end else if (load_parity) begin
                words.delete();
                for (int k = 0; k < NW; k++) words.push_back(parity_in[k*OW +: OW]);
                m_active = 1'b1; m_done = 1'b0;
            end else if (en_counterOUT && en_out) begin
                if (m_active) begin
                    m_dout = words.pop_front();
                    sb.push_back(m_dout);
                    if (words.size() == 0) begin
                        m_active = 1'b0;
                        m_done = 1'b1;
                    end
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    end

    // Monitor: compare every presented word and the status flags each cycle.
    initial begin
        logic [OW-1:0] exp_w;
        forever begin
            @(negedge clk);
            check("valid", {15'd0, parity_valid}, {15'd0, (sb.size() != 0)});
            if (parity_valid && sb.size() != 0) begin
                exp_w = sb.pop_front();
                check("word", parity_dout, exp_w);
            end
            sb.delete();
            check("dout", parity_dout, m_dout);
            check("done", {15'd0, parity_out_done}, {15'd0, m_done});
            check("err",  {15'd0, parity_err},      {15'd0, m_err});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [PW-1:0] v);
        parity_in = v;
        load_parity = 1'b1;
        tick();
        load_parity = 1'b0;
    endtask

    task automatic adv(input int n);
        en_counterOUT = 1'b1;
        en_out = 1'b1;
        repeat (n) tick();
        en_counterOUT = 1'b0;
        en_out = 1'b0;
    endtask

    initial begin
        int r;
        rst = 1'b1; rst_c = 1'b1; load_parity = 1'b0;
        en_counterOUT = 1'b0; en_out = 1'b0; parity_in = '0;
        tick(); tick();
        rst = 1'b0;

        // advance with nothing loaded
        adv(1);
        check("idle_err", {15'd0, parity_err}, 16'd1);
        check("idle_valid", {15'd0, parity_valid}, 16'd0);
        rst = 1'b1; tick(); rst = 1'b0;

        // full stream
        do_load(ramp(1'b0));
        adv(NW);
        check("last_word", parity_dout, 16'h007F);
        check("last_done", {15'd0, parity_out_done}, 16'd1);
        tick();

        // en_out gap after word 5
        do_load(ramp(1'b0));
        adv(6);
        en_counterOUT = 1'b1; en_out = 1'b0;
        repeat (3) tick();
        adv(1);
        check("after_gap", parity_dout, 16'h0006);
        adv(NW - 7);
        tick();

        // rst_c clear from DONE, then inverted pattern
        rst_c = 1'b0; tick(); rst_c = 1'b1;
        do_load(ramp(1'b1));
        adv(1);
        check("inv_first", parity_dout, 16'hFFFF);
        adv(NW - 1);

        // advance in DONE flags an error
        adv(1);
        check("done_err", {15'd0, parity_err}, 16'd1);
        rst = 1'b1; tick(); rst = 1'b0;

        // load wins over simultaneous advance at cnt=40
        do_load(ramp(1'b0));
        adv(40);
        parity_in = ramp(1'b0);
        load_parity = 1'b1; en_counterOUT = 1'b1; en_out = 1'b1;
        tick();
        load_parity = 1'b0;
        adv(1);
        check("restart_first", parity_dout, 16'h0000);
        adv(NW - 1);

        // rst mid-stream
        do_load(ramp(1'b0));
        adv(60);
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst_dout", parity_dout, 16'h0000);
        check("rst_valid", {15'd0, parity_valid}, 16'd0);
        check("rst_done", {15'd0, parity_out_done}, 16'd0);
        check("rst_err", {15'd0, parity_err}, 16'd0);

        // randomized phase
        do_load(rand_vec());
        for (int i = 0; i < 6000; i++) begin
            r = int'($urandom_range(0, 499));
            rst = (r == 0);
            rst_c = !(r == 1 || r == 2);
            load_parity = (r >= 3 && r <= 5);
            if (load_parity) parity_in = rand_vec();
            en_counterOUT = ($urandom_range(0, 9) < 8);
            en_out = ($urandom_range(0, 9) < 8);
            tick();
        end
        rst = 1'b0; rst_c = 1'b1; load_parity = 1'b0;
        en_counterOUT = 1'b0; en_out = 1'b0;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
